mem_bram_responder: RTL and testbench

- Memory-side responder for the mux_mem interface: the block that services the mux's mem_cmd / mem_addr / mem_wr_data and returns mem_rd_data.
- Backs the compact 32-bit word space (17-bit word address, 512 KiB) with on-chip block RAM.
- After every reset, runs a clear sequencer that fills the array, then serves commands with a fixed 1-cycle read latency matched to the mux's RD_WAIT → RD_VALID timing.
- Exposes access/drop statistics for the ILA and USB debug path.

---
 rtl/mem_bram_responder_if.sv | 23 ++
 rtl/mem_bram_responder.sv | 89 ++++++++
 tb/tb_mem_bram_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_bram_responder_if.sv
// Command/response bus between the memory mux (master) and the BRAM responder (slave).
// mem_cmd is a single-cycle pulse: every rising edge that sees a non-IDLE mem_cmd is one command.
// There is no valid/ready backpressure. mem_ready only tells the mux when commands will start being honoured.
interface mem_bram_responder_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            mem_cmd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_ready;

    modport master (
        output mem_cmd, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, mem_wr_data,
        output mem_rd_data, mem_ready
    );
endinterface

// File: rtl/mem_bram_responder.sv
// Block-RAM backed responder for the mux memory bus.
// After reset it clears the array, then serves READ/WRITE commands with a 1-cycle read latency.
module mem_bram_responder #(
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bram_responder_if.slave   bus,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [7:0]            drop_count,
    output logic                  dbg_state
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  is_rd, is_wr, is_drop;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_d;

    assign is_rd   = (state == S_RUN) && (bus.mem_cmd == CMD_READ);
    assign is_wr   = (state == S_RUN) && (bus.mem_cmd == CMD_WRITE);
    assign is_drop = ((state == S_INIT) && (bus.mem_cmd != 2'b00)) ||
                     ((state == S_RUN)  && (bus.mem_cmd == CMD_RSVD));
    assign dbg_state = logic'(state);

    // One shared address port: the clear pointer owns it during INIT, the bus afterwards.
    always_comb begin
        mem_a  = ptr;
        mem_d  = INIT_VALUE;
        mem_we = 1'b0;
        if (state == S_INIT) begin
            mem_we = !rst;
        end else begin
            mem_a  = bus.mem_addr;
            mem_d  = bus.mem_wr_data;
            mem_we = is_wr && !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end

    // mem_rd_data is the only read register, which keeps the read latency at one cycle.
    always_ff @(posedge clk) begin
        if (rst)        bus.mem_rd_data <= '0;
        else if (is_rd) bus.mem_rd_data <= mem[mem_a];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            ptr           <= '0;
            bus.mem_ready <= 1'b0;
            rd_count      <= '0;
            wr_count      <= '0;
            drop_count    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state         <= S_RUN;
                        bus.mem_ready <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
            if (is_rd && (rd_count != '1))        rd_count   <= rd_count + 1'b1;
            if (is_wr && (wr_count != '1))        wr_count   <= wr_count + 1'b1;
            if (is_drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bram_responder.sv
// Directed bench for mem_bram_responder: a main instance with 16-bit counters and
// a second instance with 4-bit counters for saturation.
module tb_mem_bram_responder;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;
  localparam logic [1:0] C_IDLE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_RSV = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  mem_bram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mem_bram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  logic [15:0] rd_count0, wr_count0;
  logic [7:0]  drop_count0;
  logic        dbg0;
  logic [3:0]  rd_count1, wr_count1;
  logic [7:0]  drop_count1;
  logic        dbg1;

  mem_bram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .rd_count(rd_count0), .wr_count(wr_count0), .drop_count(drop_count0), .dbg_state(dbg0)
  );

  mem_bram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst2), .bus(bus1.slave),
    .rd_count(rd_count1), .wr_count(wr_count1), .drop_count(drop_count1), .dbg_state(dbg1)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drivers: present a one-cycle command, sample 1 time unit after the edge
  task automatic step0(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus0.mem_cmd = c; bus0.mem_addr = a; bus0.mem_wr_data = d;
    @(posedge clk); #1;
    bus0.mem_cmd = C_IDLE;
  endtask

  task automatic step1(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.mem_cmd = c; bus1.mem_addr = a; bus1.mem_wr_data = d;
    @(posedge clk); #1;
    bus1.mem_cmd = C_IDLE;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus0.mem_cmd = C_IDLE; bus0.mem_addr = '0; bus0.mem_wr_data = '0;
    bus1.mem_cmd = C_IDLE; bus1.mem_addr = '0; bus1.mem_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", bus0.mem_rd_data, 32'h0);
    chk("rst_ready",   {31'b0, bus0.mem_ready}, 32'h0);
    chk("rst_rd_cnt",  {16'b0, rd_count0}, 32'h0);
    chk("rst_wr_cnt",  {16'b0, wr_count0}, 32'h0);
    chk("rst_drop",    {24'b0, drop_count0}, 32'h0);
    chk("rst_state",   {31'b0, dbg0}, 32'h0);

    // clear sequence with a READ and a WRITE pulse dropped along the way
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step0((i == 3) ? C_RD : ((i == 5) ? C_WR : C_IDLE), 4'd2, 32'h0BAD_0BAD);
      if (i == 15) chk("init_ready_early", {31'b0, bus0.mem_ready}, 32'h0);
    end
    chk("init_ready",     {31'b0, bus0.mem_ready}, 32'h1);
    chk("init_state",     {31'b0, dbg0}, 32'h1);
    chk("init_drop",      {24'b0, drop_count0}, 32'h2);
    chk("init_rd_data",   bus0.mem_rd_data, 32'h0);

    // every word holds the clear value
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(IV);
      step0(C_RD, AW'(a), '0);
      chk($sformatf("sweep_%0d", a), bus0.mem_rd_data, exp_q.pop_front());
    end
    chk("sweep_rd_cnt", {16'b0, rd_count0}, 32'd16);
    chk("sweep_wr_cnt", {16'b0, wr_count0}, 32'd0);

    // read / idle / write / idle / read on the same word
    step0(C_RD, 4'd3, '0);
    chk("cart_rd0", bus0.mem_rd_data, IV);
    step0(C_IDLE, 4'd3, '0);
    step0(C_WR, 4'd3, 32'h1234_5678);
    chk("cart_wr_hold", bus0.mem_rd_data, IV);
    step0(C_IDLE, 4'd3, '0);
    step0(C_RD, 4'd3, '0);
    chk("cart_rd1",   bus0.mem_rd_data, 32'h1234_5678);
    chk("cart_wr_cnt", {16'b0, wr_count0}, 32'd1);
    chk("cart_rd_cnt", {16'b0, rd_count0}, 32'd18);

    // write immediately followed by read of the same word, then hold
    step0(C_WR, 4'd7, 32'hDEAD_BEEF);
    step0(C_RD, 4'd7, '0);
    chk("b2b_rd", bus0.mem_rd_data, 32'hDEAD_BEEF);
    repeat (5) step0(C_IDLE, 4'd0, 32'hFFFF_FFFF);
    chk("b2b_hold",   bus0.mem_rd_data, 32'hDEAD_BEEF);
    chk("b2b_rd_cnt", {16'b0, rd_count0}, 32'd19);
    chk("b2b_wr_cnt", {16'b0, wr_count0}, 32'd2);

    // reserved command is dropped with no side effect
    step0(C_RSV, 4'd7, 32'h1111_1111);
    chk("rsv_drop",    {24'b0, drop_count0}, 32'd3);
    chk("rsv_rd_data", bus0.mem_rd_data, 32'hDEAD_BEEF);
    step0(C_RD, 4'd7, '0);
    chk("rsv_mem",     bus0.mem_rd_data, 32'hDEAD_BEEF);
    chk("rsv_wr_cnt",  {16'b0, wr_count0}, 32'd2);

    // reset on the same edge as a READ
    step0(C_WR, 4'd2, 32'hCAFE_F00D);
    bus0.mem_cmd = C_RD; bus0.mem_addr = 4'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    bus0.mem_cmd = C_IDLE;
    chk("mid_rst_rd_data", bus0.mem_rd_data, 32'h0);
    chk("mid_rst_rd_cnt",  {16'b0, rd_count0}, 32'd0);
    chk("mid_rst_ready",   {31'b0, bus0.mem_ready}, 32'h0);
    rst = 1'b0;
    repeat (15) step0(C_IDLE, 4'd0, '0);
    chk("reinit_ready_early", {31'b0, bus0.mem_ready}, 32'h0);
    step0(C_IDLE, 4'd0, '0);
    chk("reinit_ready", {31'b0, bus0.mem_ready}, 32'h1);
    step0(C_RD, 4'd2, '0);
    chk("reinit_addr2", bus0.mem_rd_data, IV);
    step0(C_RD, 4'd7, '0);
    chk("reinit_addr7", bus0.mem_rd_data, IV);
    chk("reinit_rd_cnt", {16'b0, rd_count0}, 32'd2);
    chk("reinit_wr_cnt", {16'b0, wr_count0}, 32'd0);
    chk("reinit_drop",   {24'b0, drop_count0}, 32'd0);

    // saturation on the narrow-counter instance
    rst2 = 1'b0;
    repeat (16) step1(C_IDLE, 4'd0, '0);
    chk("sat_ready", {31'b0, bus1.mem_ready}, 32'h1);
    for (int i = 0; i < 20; i++) step1(C_RD, AW'(i), '0);
    chk("sat_rd_cnt",  {28'b0, rd_count1}, 32'hF);
    chk("sat_rd_data", bus1.mem_rd_data, IV);
    repeat (300) step1(C_RSV, 4'd1, 32'h5555_5555);
    chk("sat_drop",    {24'b0, drop_count1}, 32'hFF);
    chk("sat_wr_cnt",  {28'b0, wr_count1}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
